// File: rtl/fifo_write_ctrl.sv
// Write-side controller for a 1024-entry FIFO: write pointer, occupancy and status flags.
// Optional sticky overflow flag enabled by defining FIFO_WR_OVF_EN.
module fifo_write_ctrl #(
  parameter logic [10:0] AF_LEVEL = 11'd1016
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        fifo_rd,
  input  logic        ovf_clr,
  output logic [9:0]  wptr,
  output logic        fifo_we,
  output logic [10:0] fill_level,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        fifo_almost_full,
  output logic        fifo_overflow
);

  // Handshake: wr acts as valid and ~fifo_full as ready; a word transfers on
  // every clock where fifo_we (= wr & ~fifo_full) is high. fifo_rd is already
  // qualified upstream but is re-gated here so occupancy never goes below zero.
  logic [9:0]  wptr_q;
  logic [10:0] fill_q;
  logic        rd_ok;

  assign fifo_full        = (fill_q == 11'd1024);
  assign fifo_empty       = (fill_q == 11'd0);
  assign fifo_almost_full = (fill_q >= AF_LEVEL);
  assign fifo_we          = wr & ~fifo_full;
  assign rd_ok            = fifo_rd & ~fifo_empty;
  assign wptr             = wptr_q;
  assign fill_level       = fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= 10'd0;
      fill_q <= 11'd0;
    end else begin
      if (fifo_we) begin
        wptr_q <= wptr_q + 10'd1;
      end
      // A simultaneous read and write leaves occupancy unchanged.
      if (fifo_we && !rd_ok) begin
        fill_q <= fill_q + 11'd1;
      end else if (rd_ok && !fifo_we) begin
        fill_q <= fill_q - 11'd1;
      end
    end
  end

`ifdef FIFO_WR_OVF_EN
  logic ovf_q;

  // Set has priority over clear so a clear cannot hide a coincident overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (wr && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign fifo_overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign fifo_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed testbench for fifo_write_ctrl; overflow expectations follow FIFO_WR_OVF_EN.
module tb_fifo_write_ctrl;

`ifdef FIFO_WR_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic        fifo_rd;
  logic        ovf_clr;
  logic [9:0]  wptr;
  logic        fifo_we;
  logic [10:0] fill_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_almost_full;
  logic        fifo_overflow;

  int total_cnt;
  int bad_cnt;
  int we_bad;

  fifo_write_ctrl #(.AF_LEVEL(11'd1016)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr               (wr),
    .fifo_rd          (fifo_rd),
    .ovf_clr          (ovf_clr),
    .wptr             (wptr),
    .fifo_we          (fifo_we),
    .fill_level       (fill_level),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_overflow    (fifo_overflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n);
    wr = 1'b1;
    repeat (n) tick();
    wr = 1'b0;
  endtask

  task automatic do_reset();
    wr = 1'b0; fifo_rd = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0;
    wr = 1'b0; fifo_rd = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;
    #1;
    // wr during reset: strobe follows wr, no state changes
    wr = 1'b1;
    #1;
    chk("we_in_reset", 32'(fifo_we), 32'd1);
    tick();
    chk("wptr_in_reset", 32'(wptr), 32'd0);
    chk("fill_in_reset", 32'(fill_level), 32'd0);
    wr = 1'b0;
    rst_n = 1'b1;
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_af", 32'(fifo_almost_full), 32'd0);
    chk("rst_ovf", 32'(fifo_overflow), 32'd0);

    // 5 writes, strobe high on every one
    we_bad = 0;
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (fifo_we !== 1'b1) we_bad++;
      tick();
    end
    wr = 1'b0;
    chk("we_5_cycles_bad", 32'(we_bad), 32'd0);
    chk("wptr_5", 32'(wptr), 32'd5);
    chk("fill_5", 32'(fill_level), 32'd5);
    chk("empty_5", 32'(fifo_empty), 32'd0);

    // async reset mid-burst at 300
    write_n(295);
    chk("fill_300", 32'(fill_level), 32'd300);
    wr = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_fill", 32'(fill_level), 32'd0);
    chk("async_wptr", 32'(wptr), 32'd0);
    chk("async_empty", 32'(fifo_empty), 32'd1);
    chk("async_we", 32'(fifo_we), 32'd1);
    tick();
    chk("held_in_reset", 32'(fill_level), 32'd0);
    wr = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_fill", 32'(fill_level), 32'd0);

    // almost-full threshold
    write_n(1015);
    chk("fill_1015", 32'(fill_level), 32'd1015);
    chk("af_1015", 32'(fifo_almost_full), 32'd0);
    write_n(1);
    chk("af_1016", 32'(fifo_almost_full), 32'd1);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("fill_after_rd", 32'(fill_level), 32'd1015);
    chk("af_after_rd", 32'(fifo_almost_full), 32'd0);

    // 1024 writes from empty
    do_reset();
    write_n(1023);
    chk("full_1023", 32'(fifo_full), 32'd0);
    write_n(1);
    chk("full_1024", 32'(fifo_full), 32'd1);
    chk("wptr_wrap", 32'(wptr), 32'd0);
    chk("fill_1024", 32'(fill_level), 32'd1024);
    wr = 1'b1;
    #1;
    chk("we_when_full", 32'(fifo_we), 32'd0);
    tick();
    chk("fill_stuck_1024", 32'(fill_level), 32'd1024);
    chk("wptr_stuck", 32'(wptr), 32'd0);
    chk("ovf_set", 32'(fifo_overflow), 32'(OVF_EN));
    ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(fifo_overflow), 32'(OVF_EN));
    wr = 1'b0;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(fifo_overflow), 32'd0);

    // full with simultaneous wr and rd: no write-through
    wr = 1'b1; fifo_rd = 1'b1;
    #1;
    chk("we_full_wr_rd", 32'(fifo_we), 32'd0);
    tick();
    wr = 1'b0; fifo_rd = 1'b0;
    chk("fill_wr_rd", 32'(fill_level), 32'd1023);
    chk("wptr_wr_rd", 32'(wptr), 32'd0);
    chk("full_wr_rd", 32'(fifo_full), 32'd0);

    // drain, then read at empty must not underflow
    fifo_rd = 1'b1;
    repeat (1023) tick();
    chk("drained", 32'(fill_level), 32'd0);
    chk("drained_empty", 32'(fifo_empty), 32'd1);
    tick();
    chk("no_underflow", 32'(fill_level), 32'd0);
    wr = 1'b1;
    #1;
    chk("we_at_empty", 32'(fifo_we), 32'd1);
    tick();
    wr = 1'b0; fifo_rd = 1'b0;
    chk("fill_empty_wr_rd", 32'(fill_level), 32'd1);
    chk("empty_deassert", 32'(fifo_empty), 32'd0);
    chk("wptr_final", 32'(wptr), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
